if_busca: RTL and testbench



---
 rtl/if_busca_if.sv | 23 ++
 rtl/if_busca.sv | 111 +++++++++++
 tb/tb_if_busca.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_busca_if.sv
// Instruction-memory fetch bus: registered req/addr from the fetch stage, one-cycle ack with data.
interface if_busca_if #(
  parameter int unsigned LARGURA = 16
) ();
  logic               mem_req;
  logic [LARGURA-1:0] mem_addr;
  logic               mem_ack;
  logic [LARGURA-1:0] mem_dado;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_dado
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_dado
  );
endinterface

// File: rtl/if_busca.sv
// Instruction-fetch stage: owns the PC, fetches over req/ack and fills the IF/ID register,
// with a one-entry hold buffer for stalls and branch flush/redirect.
module if_busca #(
  parameter int unsigned        LARGURA  = 16,
  parameter logic [LARGURA-1:0] PC_RESET = '0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic               desvio,
  input  logic [LARGURA-1:0] alvo,
  if_busca_if.master         mem,
  output logic [LARGURA-1:0] instrucao,
  output logic [LARGURA-1:0] pc_id,
  output logic               valido
);

  typedef enum logic [1:0] {StIdle, StBusca, StDescarta, StEspera} estado_e;

  estado_e            estado_q;
  logic               mem_req_q;
  logic [LARGURA-1:0] pc_q;
  logic [LARGURA-1:0] end_pend_q;
  logic [LARGURA-1:0] pc_desvio_q;
  logic [LARGURA-1:0] buf_dado_q;
  logic [LARGURA-1:0] buf_pc_q;
  logic [LARGURA-1:0] alvo_descarta;

  // A redirect arriving in the same cycle as the dropped word's ack beats the stored target.
  assign alvo_descarta = desvio ? alvo : pc_desvio_q;

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = end_pend_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q    <= StIdle;
      mem_req_q   <= 1'b0;
      pc_q        <= PC_RESET;
      end_pend_q  <= '0;
      pc_desvio_q <= '0;
      buf_dado_q  <= '0;
      buf_pc_q    <= '0;
      instrucao   <= '0;
      pc_id       <= '0;
      valido      <= 1'b0;
    end else begin
      unique case (estado_q)
        StIdle: begin
          mem_req_q  <= 1'b1;
          end_pend_q <= pc_q;
          pc_q       <= pc_q + LARGURA'(1);
          estado_q   <= StBusca;
        end
        StBusca: begin
          if (desvio && mem.mem_ack) begin
            valido     <= 1'b0;
            end_pend_q <= alvo;
            pc_q       <= alvo + LARGURA'(1);
          end else if (desvio) begin
            valido      <= 1'b0;
            pc_desvio_q <= alvo;
            estado_q    <= StDescarta;
          end else if (mem.mem_ack && (!valido || !stall)) begin
            instrucao  <= mem.mem_dado;
            pc_id      <= end_pend_q;
            valido     <= 1'b1;
            end_pend_q <= pc_q;
            pc_q       <= pc_q + LARGURA'(1);
          end else if (mem.mem_ack) begin
            // Decode is stalled on a real word: park this one and stop requesting.
            buf_dado_q <= mem.mem_dado;
            buf_pc_q   <= end_pend_q;
            mem_req_q  <= 1'b0;
            estado_q   <= StEspera;
          end else if (!stall) begin
            valido <= 1'b0;
          end
        end
        StDescarta: begin
          valido <= 1'b0;
          if (mem.mem_ack) begin
            end_pend_q <= alvo_descarta;
            pc_q       <= alvo_descarta + LARGURA'(1);
            estado_q   <= StBusca;
          end else if (desvio) begin
            pc_desvio_q <= alvo;
          end
        end
        StEspera: begin
          if (desvio) begin
            valido     <= 1'b0;
            mem_req_q  <= 1'b1;
            end_pend_q <= alvo;
            pc_q       <= alvo + LARGURA'(1);
            estado_q   <= StBusca;
          end else if (!stall) begin
            instrucao  <= buf_dado_q;
            pc_id      <= buf_pc_q;
            valido     <= 1'b1;
            mem_req_q  <= 1'b1;
            end_pend_q <= pc_q;
            pc_q       <= pc_q + LARGURA'(1);
            estado_q   <= StBusca;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_busca.sv
// Bench for if_busca: directed scenarios with a queue of expected IF/ID words per DUT.
module tb_if_busca;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        reset_b;
  logic        stall;
  logic        desvio;
  logic [15:0] alvo;
  logic        zero_bit  = 1'b0;
  logic [15:0] zero_word = 16'h0000;
  logic [15:0] instrucao_a, pc_id_a, instrucao_b, pc_id_b;
  logic        valido_a, valido_b;

  if_busca_if #(.LARGURA(16)) bus_a ();
  if_busca_if #(.LARGURA(16)) bus_b ();

  if_busca #(.LARGURA(16), .PC_RESET(16'h0010)) u_a (
    .clock     (clock),
    .reset     (reset),
    .stall     (stall),
    .desvio    (desvio),
    .alvo      (alvo),
    .mem       (bus_a),
    .instrucao (instrucao_a),
    .pc_id     (pc_id_a),
    .valido    (valido_a)
  );

  if_busca #(.LARGURA(16), .PC_RESET(16'hFFFE)) u_b (
    .clock     (clock),
    .reset     (reset_b),
    .stall     (zero_bit),
    .desvio    (zero_bit),
    .alvo      (zero_word),
    .mem       (bus_b),
    .instrucao (instrucao_b),
    .pc_id     (pc_id_b),
    .valido    (valido_b)
  );

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] ins;
  } esp_t;

  esp_t sb_a[$];
  esp_t sb_b[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [15:0] palavra(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    reset_b = 1'b1;
    stall  = 1'b0;
    desvio = 1'b0;
    alvo   = 16'h0000;
    bus_a.mem_ack = 1'b0;
    bus_a.mem_dado = 16'h0000;
    bus_b.mem_ack = 1'b0;
    bus_b.mem_dado = 16'h0000;
    tick();
    tick();
    total++;
    if (bus_a.mem_req !== 1'b0) begin
      bad++; $display("FAIL reset_req got=%b exp=0", bus_a.mem_req);
    end
    total++;
    if (bus_a.mem_addr !== 16'h0000) begin
      bad++; $display("FAIL reset_addr got=%h exp=0000", bus_a.mem_addr);
    end
    total++;
    if (instrucao_a !== 16'h0000 || pc_id_a !== 16'h0000) begin
      bad++; $display("FAIL reset_ifid got ins=%h pc=%h exp 0000/0000", instrucao_a, pc_id_a);
    end
    total++;
    if (valido_a !== 1'b0 || valido_b !== 1'b0) begin
      bad++; $display("FAIL reset_valido got a=%b b=%b exp 0/0", valido_a, valido_b);
    end
  endtask

  task automatic test_stream(inout logic [15:0] exp_addr);
    esp_t e;
    reset = 1'b0;
    tick();
    exp_addr = 16'h0010;
    total++;
    if (bus_a.mem_req !== 1'b1 || bus_a.mem_addr !== exp_addr || valido_a !== 1'b0) begin
      bad++;
      $display("FAIL first_req got req=%b addr=%h valido=%b exp 1/0010/0",
               bus_a.mem_req, bus_a.mem_addr, valido_a);
    end
    for (int i = 0; i < 8; i++) begin
      bus_a.mem_ack  = 1'b1;
      bus_a.mem_dado = palavra(bus_a.mem_addr);
      sb_a.push_back('{pc: exp_addr, ins: palavra(exp_addr)});
      tick();
      exp_addr = exp_addr + 16'd1;
      total++;
      if (bus_a.mem_addr !== exp_addr) begin
        bad++; $display("FAIL stream_addr[%0d] got=%h exp=%h", i, bus_a.mem_addr, exp_addr);
      end
      total++;
      if (valido_a !== 1'b1 || sb_a.size() == 0) begin
        bad++; $display("FAIL stream_valido[%0d] got=%b exp=1", i, valido_a);
      end else begin
        e = sb_a.pop_front();
        total++;
        if ({pc_id_a, instrucao_a} !== e) begin
          bad++;
          $display("FAIL stream_word[%0d] got pc=%h ins=%h exp pc=%h ins=%h",
                   i, pc_id_a, instrucao_a, e.pc, e.ins);
        end
      end
    end
  endtask

  task automatic test_wait_states(inout logic [15:0] exp_addr);
    esp_t e;
    logic ack;
    for (int j = 0; j < 9; j++) begin
      ack = (j % 3 == 2);
      bus_a.mem_ack  = ack;
      bus_a.mem_dado = ack ? palavra(bus_a.mem_addr) : 16'($urandom);
      if (ack) sb_a.push_back('{pc: exp_addr, ins: palavra(exp_addr)});
      tick();
      if (ack) exp_addr = exp_addr + 16'd1;
      total++;
      if (bus_a.mem_addr !== exp_addr) begin
        bad++; $display("FAIL wait_addr[%0d] got=%h exp=%h", j, bus_a.mem_addr, exp_addr);
      end
      total++;
      if (valido_a !== ack) begin
        bad++; $display("FAIL wait_valido[%0d] got=%b exp=%b", j, valido_a, ack);
      end else if (ack) begin
        e = sb_a.pop_front();
        total++;
        if ({pc_id_a, instrucao_a} !== e) begin
          bad++;
          $display("FAIL wait_word[%0d] got pc=%h ins=%h exp pc=%h ins=%h",
                   j, pc_id_a, instrucao_a, e.pc, e.ins);
        end
      end
    end
    bus_a.mem_ack = 1'b0;
  endtask

  task automatic test_stall();
    esp_t e;
    // Redirect to 0004 (ack discarded) so the parked word lands at 0005.
    desvio = 1'b1; alvo = 16'h0004;
    bus_a.mem_ack = 1'b1; bus_a.mem_dado = 16'($urandom);
    tick();
    desvio = 1'b0;
    total++;
    if (bus_a.mem_addr !== 16'h0004 || valido_a !== 1'b0) begin
      bad++; $display("FAIL stall_setup got addr=%h valido=%b exp 0004/0", bus_a.mem_addr, valido_a);
    end
    bus_a.mem_dado = palavra(bus_a.mem_addr);
    sb_a.push_back('{pc: 16'h0004, ins: palavra(16'h0004)});
    tick();
    e = sb_a.pop_front();
    total++;
    if ({pc_id_a, instrucao_a, valido_a} !== {e.pc, e.ins, 1'b1}) begin
      bad++; $display("FAIL stall_pre got pc=%h ins=%h v=%b exp pc=%h ins=%h v=1",
                      pc_id_a, instrucao_a, valido_a, e.pc, e.ins);
    end
    stall = 1'b1;
    bus_a.mem_dado = 16'h1234;
    sb_a.push_back('{pc: 16'h0005, ins: 16'h1234});
    for (int k = 0; k < 4; k++) begin
      tick();
      bus_a.mem_ack = 1'b0;
      total++;
      if (bus_a.mem_req !== 1'b0 ||
          {pc_id_a, instrucao_a, valido_a} !== {16'h0004, palavra(16'h0004), 1'b1}) begin
        bad++; $display("FAIL stall_hold[%0d] got req=%b pc=%h ins=%h v=%b exp 0/0004/%h/1",
                        k, bus_a.mem_req, pc_id_a, instrucao_a, valido_a, palavra(16'h0004));
      end
    end
    stall = 1'b0;
    tick();
    e = sb_a.pop_front();
    total++;
    if ({pc_id_a, instrucao_a, valido_a} !== {e.pc, e.ins, 1'b1}) begin
      bad++; $display("FAIL stall_release got pc=%h ins=%h v=%b exp pc=%h ins=%h v=1",
                      pc_id_a, instrucao_a, valido_a, e.pc, e.ins);
    end
    total++;
    if (bus_a.mem_req !== 1'b1 || bus_a.mem_addr !== 16'h0006) begin
      bad++; $display("FAIL stall_resume got req=%b addr=%h exp 1/0006", bus_a.mem_req,
                      bus_a.mem_addr);
    end
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      total++;
      if ({pc_id_a, instrucao_a, valido_a} !== {16'h0005, 16'h1234, 1'b1} ||
          bus_a.mem_addr !== 16'h0006) begin
        bad++; $display("FAIL unacked_stall[%0d] got pc=%h ins=%h v=%b addr=%h exp 0005/1234/1/0006",
                        k, pc_id_a, instrucao_a, valido_a, bus_a.mem_addr);
      end
    end
    stall = 1'b0;
    bus_a.mem_ack = 1'b1;
    bus_a.mem_dado = palavra(bus_a.mem_addr);
    sb_a.push_back('{pc: 16'h0006, ins: palavra(16'h0006)});
    tick();
    bus_a.mem_ack = 1'b0;
    e = sb_a.pop_front();
    total++;
    if ({pc_id_a, instrucao_a, valido_a} !== {e.pc, e.ins, 1'b1} || bus_a.mem_addr !== 16'h0007) begin
      bad++; $display("FAIL stall_after got pc=%h ins=%h v=%b addr=%h exp pc=%h ins=%h v=1 addr=0007",
                      pc_id_a, instrucao_a, valido_a, bus_a.mem_addr, e.pc, e.ins);
    end
  endtask

  // Redirect while a request is pending, then take the ack and fetch from the new target.
  task automatic branch_pending(input logic [15:0] held, input logic [15:0] t1,
                                input logic [15:0] t2, input logic late, input string nome);
    esp_t e;
    logic [15:0] alvo_final;
    alvo_final = late ? t2 : t1;
    desvio = 1'b1; alvo = t1; bus_a.mem_ack = 1'b0;
    tick();
    desvio = 1'b0;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (valido_a !== 1'b0 || bus_a.mem_addr !== held || bus_a.mem_req !== 1'b1) begin
        bad++; $display("FAIL %s_discard[%0d] got v=%b addr=%h req=%b exp 0/%h/1",
                        nome, k, valido_a, bus_a.mem_addr, bus_a.mem_req, held);
      end
      if (k == 0) begin
        desvio = late; alvo = t2;
        if (late) bus_a.mem_ack = 1'b0;
        tick();
        desvio = 1'b0;
      end
    end
    bus_a.mem_ack = 1'b1; bus_a.mem_dado = palavra(bus_a.mem_addr);
    tick();
    total++;
    if (bus_a.mem_addr !== alvo_final || valido_a !== 1'b0) begin
      bad++; $display("FAIL %s_redirect got addr=%h v=%b exp %h/0", nome, bus_a.mem_addr,
                      valido_a, alvo_final);
    end
    bus_a.mem_dado = palavra(bus_a.mem_addr);
    sb_a.push_back('{pc: alvo_final, ins: palavra(alvo_final)});
    tick();
    bus_a.mem_ack = 1'b0;
    e = sb_a.pop_front();
    total++;
    if ({pc_id_a, instrucao_a, valido_a} !== {e.pc, e.ins, 1'b1} ||
        bus_a.mem_addr !== alvo_final + 16'd1) begin
      bad++; $display("FAIL %s_target got pc=%h ins=%h v=%b addr=%h exp pc=%h ins=%h v=1",
                      nome, pc_id_a, instrucao_a, valido_a, bus_a.mem_addr, e.pc, e.ins);
    end
  endtask

  task automatic test_branch();
    esp_t e;
    branch_pending(16'h0007, 16'h0100, 16'h0000, 1'b0, "br_single");
    branch_pending(16'h0101, 16'h0300, 16'h0200, 1'b1, "br_second");
    // Target given in the same cycle as the dropped word's ack.
    desvio = 1'b1; alvo = 16'h0300; bus_a.mem_ack = 1'b0;
    tick();
    alvo = 16'h0500; bus_a.mem_ack = 1'b1; bus_a.mem_dado = 16'($urandom);
    tick();
    desvio = 1'b0;
    total++;
    if (bus_a.mem_addr !== 16'h0500 || valido_a !== 1'b0) begin
      bad++; $display("FAIL br_ackcycle got addr=%h v=%b exp 0500/0", bus_a.mem_addr, valido_a);
    end
    bus_a.mem_dado = palavra(bus_a.mem_addr);
    sb_a.push_back('{pc: 16'h0500, ins: palavra(16'h0500)});
    tick();
    bus_a.mem_ack = 1'b0;
    e = sb_a.pop_front();
    total++;
    if ({pc_id_a, instrucao_a, valido_a} !== {e.pc, e.ins, 1'b1}) begin
      bad++; $display("FAIL br_ackcycle_word got pc=%h ins=%h v=%b exp pc=%h ins=%h v=1",
                      pc_id_a, instrucao_a, valido_a, e.pc, e.ins);
    end
  endtask

  task automatic test_branch_over_stall();
    esp_t e;
    stall = 1'b1; bus_a.mem_ack = 1'b1; bus_a.mem_dado = 16'($urandom);
    tick();
    bus_a.mem_ack = 1'b0;
    total++;
    if (bus_a.mem_req !== 1'b0 || valido_a !== 1'b1) begin
      bad++; $display("FAIL bs_espera got req=%b v=%b exp 0/1", bus_a.mem_req, valido_a);
    end
    desvio = 1'b1; alvo = 16'h0400;
    tick();
    desvio = 1'b0;
    total++;
    if (valido_a !== 1'b0 || bus_a.mem_req !== 1'b1 || bus_a.mem_addr !== 16'h0400) begin
      bad++; $display("FAIL bs_flush got v=%b req=%b addr=%h exp 0/1/0400", valido_a,
                      bus_a.mem_req, bus_a.mem_addr);
    end
    stall = 1'b0;
    bus_a.mem_ack = 1'b1; bus_a.mem_dado = palavra(bus_a.mem_addr);
    sb_a.push_back('{pc: 16'h0400, ins: palavra(16'h0400)});
    tick();
    bus_a.mem_ack = 1'b0;
    e = sb_a.pop_front();
    total++;
    if ({pc_id_a, instrucao_a, valido_a} !== {e.pc, e.ins, 1'b1} || bus_a.mem_addr !== 16'h0401) begin
      bad++; $display("FAIL bs_target got pc=%h ins=%h v=%b addr=%h exp pc=%h ins=%h v=1 addr=0401",
                      pc_id_a, instrucao_a, valido_a, bus_a.mem_addr, e.pc, e.ins);
    end
  endtask

  task automatic test_reset_mid();
    esp_t e;
    reset = 1'b1; bus_a.mem_ack = 1'b0;
    tick();
    total++;
    if ({bus_a.mem_req, bus_a.mem_addr, instrucao_a, pc_id_a, valido_a} !== 50'd0) begin
      bad++; $display("FAIL rmid_reset got req=%b addr=%h ins=%h pc=%h v=%b exp all 0",
                      bus_a.mem_req, bus_a.mem_addr, instrucao_a, pc_id_a, valido_a);
    end
    bus_a.mem_ack = 1'b1; bus_a.mem_dado = 16'($urandom);
    tick();
    reset = 1'b0;
    tick();
    total++;
    if (bus_a.mem_req !== 1'b1 || bus_a.mem_addr !== 16'h0010 || valido_a !== 1'b0 ||
        instrucao_a !== 16'h0000) begin
      bad++; $display("FAIL rmid_restart got req=%b addr=%h v=%b ins=%h exp 1/0010/0/0000",
                      bus_a.mem_req, bus_a.mem_addr, valido_a, instrucao_a);
    end
    bus_a.mem_dado = palavra(bus_a.mem_addr);
    sb_a.push_back('{pc: 16'h0010, ins: palavra(16'h0010)});
    tick();
    bus_a.mem_ack = 1'b0;
    e = sb_a.pop_front();
    total++;
    if ({pc_id_a, instrucao_a, valido_a} !== {e.pc, e.ins, 1'b1} || bus_a.mem_addr !== 16'h0011) begin
      bad++; $display("FAIL rmid_first got pc=%h ins=%h v=%b addr=%h exp pc=%h ins=%h v=1 addr=0011",
                      pc_id_a, instrucao_a, valido_a, bus_a.mem_addr, e.pc, e.ins);
    end
    total++;
    if (sb_a.size() != 0) begin
      bad++; $display("FAIL sb_a_leftover got=%0d exp=0", sb_a.size());
    end
  endtask

  task automatic test_wrap();
    esp_t e;
    logic [15:0] eb;
    reset_b = 1'b0;
    tick();
    eb = 16'hFFFE;
    total++;
    if (bus_b.mem_req !== 1'b1 || bus_b.mem_addr !== eb) begin
      bad++; $display("FAIL wrap_first got req=%b addr=%h exp 1/FFFE", bus_b.mem_req, bus_b.mem_addr);
    end
    for (int i = 0; i < 4; i++) begin
      bus_b.mem_ack = 1'b1;
      bus_b.mem_dado = palavra(bus_b.mem_addr);
      sb_b.push_back('{pc: eb, ins: palavra(eb)});
      tick();
      eb = eb + 16'd1;
      total++;
      if (valido_b !== 1'b1 || sb_b.size() == 0) begin
        bad++; $display("FAIL wrap_valido[%0d] got=%b exp=1", i, valido_b);
      end else begin
        e = sb_b.pop_front();
        total++;
        if ({pc_id_b, instrucao_b} !== e || bus_b.mem_addr !== eb) begin
          bad++; $display("FAIL wrap_word[%0d] got pc=%h ins=%h addr=%h exp pc=%h ins=%h addr=%h",
                          i, pc_id_b, instrucao_b, bus_b.mem_addr, e.pc, e.ins, eb);
        end
      end
    end
    bus_b.mem_ack = 1'b0;
    total++;
    if (pc_id_b !== 16'h0001) begin
      bad++; $display("FAIL wrap_end got pc=%h exp=0001", pc_id_b);
    end
  endtask

  initial begin
    logic [15:0] exp_addr;
    exp_addr = 16'h0000;
    test_reset();
    test_stream(exp_addr);
    test_wait_states(exp_addr);
    test_stall();
    test_branch();
    test_branch_over_stall();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
